rpn_stack_calc: RTL and testbench
=================================

# rpn_stack_calc

Parametrised successor of the session-7 RPN calculator. It sequences operand A, operand B and an opcode entered through one debounced Enter button, and shows the result with NZCV flags. Generalisations over the previous generation:
- data width and debounce length are parameters;
- a second debounced Undo button steps the sequence back one state, restoring the previous operand.

It sits between the board switch/button inputs and the 7-segment display driver.

## Interface
- WIDTH, 16: operand and result width; must be ≥ 4.
- N_DEBOUNCER, 10: consecutive stable samples needed to accept a button edge; must be ≥ 2.
- clk  in  1: system clock; all logic on the rising edge.
- reset  in  1: synchronous, active-high reset.
- Enter  in  1: raw Enter button, asynchronous to clk, bouncing.
- Undo  in  1: raw Undo button, asynchronous to clk, bouncing.
- DataIn  in  WIDTH: switch value (operand or opcode).
- ToDisplay  out  WIDTH: registered display value.
- Flags  out  4: {N,Z,C,V}; non-zero only in SHOW.
- Status  out  3: current state code.

## Operation
- Each button goes through a 2-flop synchroniser, then a debouncer.
  - Emits one 1-cycle pulse per accepted press.
  - A press is accepted after N_DEBOUNCER consecutive high samples.
  - It is re-armed only after N_DEBOUNCER consecutive low samples.
  - Holding the button never produces a second pulse.
- States and Status codes:
  - WAIT_A = 3'd0
  - WAIT_B = 3'd1
  - WAIT_OP = 3'd2
  - SHOW = 3'd3
  - Codes 4–7 are unused. Any illegal state returns to WAIT_A.
- Enter pulse transitions:
  - WAIT_A: A ← DataIn, go to WAIT_B.
  - WAIT_B: B ← DataIn, go to WAIT_OP.
  - WAIT_OP, legal opcode: Op ← DataIn[2:0], compute result and flags, go to SHOW. An illegal opcode is ignored and the state is held.
  - SHOW: clear A, B, Op, result and Flags, go to WAIT_A.
- Undo pulse transitions:
  - WAIT_B: go to WAIT_A and clear A.
  - WAIT_OP: go to WAIT_B and clear B.
  - SHOW: go to WAIT_OP and clear result and Flags; A and B are kept.
  - WAIT_A: no effect.
- If Enter and Undo pulse in the same cycle, Undo wins and the Enter pulse is discarded.
- Opcodes (DataIn[2:0]; upper bits ignored):
  - 0 ADD: A+B
  - 1 SUB: A−B
  - 2 OR
  - 3 AND
  - 4 XOR
  - 5–7: illegal
- Result width is WIDTH; the carry-out is captured only in C.
- Flags:
  - N = result[WIDTH-1].
  - Z = (result == 0).
  - C for ADD = carry-out of A+B.
  - C for SUB = carry-out of A+~B+1, so 1 means no borrow (A ≥ B unsigned).
  - V = two's-complement overflow for ADD and SUB.
  - For logic ops, C = V = 0.
- ToDisplay:
  - In WAIT_A, WAIT_B and WAIT_OP it shows DataIn, registered with a 1-cycle lag.
  - In SHOW it shows the result.

## Timing
- Reset values: ToDisplay = 0, Flags = 0, Status = WAIT_A.
  - A, B, Op, result and the debouncer counters/armed bits are all cleared.
  - Reset mid-operation aborts immediately, on the edge where reset is sampled high.
- A button still held when reset releases yields a pulse after N_DEBOUNCER samples. No press is remembered across reset.
- Latency from the first high synchronised sample:
  - The pulse is asserted at sample N_DEBOUNCER.
  - Status, operand registers, result and Flags update on the following edge.
  - ToDisplay updates in the same cycle as Status in SHOW.
  - Total delay is 2 (synchroniser) + N_DEBOUNCER + 1 edges after the raw button rises.
- A glitch shorter than N_DEBOUNCER cycles produces no pulse. The counter restarts on any mismatching sample.
- The result is computed combinationally from A, B and DataIn[2:0] and registered on the accepting Enter. There is no multicycle path.

## Structure
- Package rpn_pkg holds:
  - typedef enum logic [2:0] state_t with the Status codes;
  - typedef enum logic [2:0] op_t;
  - flag index constants FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0.
- Sub-module btn_debouncer(#N_DEBOUNCER), instantiated twice. It contains the synchroniser, counter, armed bit and a 1-cycle pulse output.
- The top level holds the FSM, operand/op registers, ALU and flag logic, and the display mux.

## Test plan
All scenarios use WIDTH = 16 and N_DEBOUNCER = 10.
- ADD: enter A = FFFF, B = 0101, op 0 → SHOW, ToDisplay = 0100, Flags = 4'b0010. A further Enter → WAIT_A, Flags = 0.
- SUB: FFFF − 0101 → FEFE, Flags = 4'b1010. ADD 7FFF + 0001 → 8000, Flags = 4'b1001.
- Logic ops:
  - FFFF OR 0101 → FFFF, Flags = 1000.
  - FFFF AND 0003 → 0003, Flags = 0000.
  - 00FF XOR 00FF → 0000, Flags = 0100.
- Undo:
  - In SHOW after FFFF + 0101: Undo → WAIT_OP with Flags = 0; then op 1 → FEFE.
  - From WAIT_OP: Undo twice → WAIT_A. A third Undo → stays WAIT_A.
- Debounce and priority:
  - A 6-cycle Enter glitch → no state change.
  - Enter held for 200 cycles → exactly one transition.
  - Enter and Undo pulses coincident in WAIT_B → WAIT_A.
  - Illegal op 6 in WAIT_OP → stays WAIT_OP.
- Reset:
  - Assert reset in WAIT_OP → next edge: Status = 0, ToDisplay = 0, Flags = 0.
  - Enter held across reset release → exactly one pulse, N_DEBOUNCER cycles later.

Source files
------------

// File: rtl/rpn_stack_calc_pkg.sv
// ---------------------------------------------------------------------------
// rpn_pkg
// Shared types for the RPN stack calculator:
//   state_t  - sequencer state, value is also the Status output code
//   op_t     - ALU opcode carried on DataIn[2:0]
//   FLAG_*   - bit positions of N, Z, C, V inside the 4-bit Flags vector
//   is_legal_op() - opcode range check (codes above XOR are rejected)
// ---------------------------------------------------------------------------
package rpn_pkg;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    SHOW    = 3'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_OR  = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4
  } op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic is_legal_op(input logic [2:0] code);
    return (code <= 3'd4);
  endfunction

endpackage

// File: rtl/rpn_stack_calc_btn_debouncer.sv
// ---------------------------------------------------------------------------
// btn_debouncer
// Two-flop synchroniser followed by a run-length debouncer for one raw button.
// Ports:
//   clk      - system clock
//   reset    - synchronous active-high reset
//   i_btn    - raw, bouncing, asynchronous button level
//   o_pulse  - one-cycle pulse per accepted press
// A press is accepted after N_DEBOUNCER consecutive high synchronised
// samples; the detector is then locked until N_DEBOUNCER consecutive low
// samples have been seen, so a held button yields exactly one pulse.
// ---------------------------------------------------------------------------
module btn_debouncer #(
  parameter int N_DEBOUNCER = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int                CNT_W    = $clog2(N_DEBOUNCER);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_DEBOUNCER - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_locked;   // 0 = armed (waiting for high run), 1 = waiting for release
  logic             r_pulse;

  logic w_sample;
  logic w_match;
  logic w_done;

  assign w_sample = r_sync[1];
  // The level we are counting towards flips with the lock bit.
  assign w_match  = w_sample ^ r_locked;
  // The counter holds N-1 when the N-th matching sample arrives.
  assign w_done   = w_match && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_locked <= 1'b0;
      r_pulse  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_pulse <= w_done && !r_locked;
      if (!w_match || w_done) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_done) begin
        r_locked <= !r_locked;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/rpn_stack_calc.sv
// ---------------------------------------------------------------------------
// rpn_stack_calc
// Three-step RPN calculator: Enter captures operand A, operand B, then an
// opcode, and the result is shown with NZCV flags. Undo steps back one state.
// Ports:
//   clk        - system clock
//   reset      - synchronous active-high reset
//   Enter      - raw Enter button (debounced internally)
//   Undo       - raw Undo button (debounced internally)
//   DataIn     - switch value: operand, or opcode on [2:0]
//   ToDisplay  - registered display value (DataIn echo, or result in SHOW)
//   Flags      - {N,Z,C,V}, only non-zero in SHOW
//   Status     - current state code
// ---------------------------------------------------------------------------
module rpn_stack_calc
  import rpn_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int N_DEBOUNCER = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Enter,
  input  logic             Undo,
  input  logic [WIDTH-1:0] DataIn,
  output logic [WIDTH-1:0] ToDisplay,
  output logic [3:0]       Flags,
  output logic [2:0]       Status
);

  localparam int               MSB    = WIDTH - 1;
  localparam logic [WIDTH:0]   W1_ONE = {{WIDTH{1'b0}}, 1'b1};

  // ---------------- buttons ----------------
  logic [1:0] w_btn_raw;
  logic [1:0] w_btn_pulse;
  logic       w_enter;
  logic       w_undo;

  assign w_btn_raw = {Undo, Enter};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      btn_debouncer #(
        .N_DEBOUNCER(N_DEBOUNCER)
      ) u_debouncer (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (w_btn_raw[gi]),
        .o_pulse (w_btn_pulse[gi])
      );
    end
  endgenerate

  assign w_enter = w_btn_pulse[0];
  assign w_undo  = w_btn_pulse[1];

  // ---------------- registers ----------------
  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  op_t              r_op;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic [WIDTH-1:0] r_disp;

  state_t           w_state_next;
  logic [WIDTH-1:0] w_a_next;
  logic [WIDTH-1:0] w_b_next;
  op_t              w_op_next;
  logic [WIDTH-1:0] w_result_next;
  logic [3:0]       w_flags_next;
  logic [WIDTH-1:0] w_disp_next;

  // ---------------- ALU ----------------
  logic [2:0]       w_op_sel;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic             w_alu_v;
  logic [3:0]       w_alu_flags;

  // While waiting for the opcode the ALU follows the switches; elsewhere it
  // follows the latched opcode and so keeps reproducing the stored result.
  assign w_op_sel = (r_state == WAIT_OP) ? DataIn[2:0] : r_op;

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  // Subtraction as A + ~B + 1 so the top bit is the "no borrow" carry.
  assign w_diff = {1'b0, r_a} + {1'b0, ~r_b} + W1_ONE;

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (w_op_sel)
      OP_ADD: begin
        w_alu_res = w_sum[MSB:0];
        w_alu_c   = w_sum[WIDTH];
        // Same-sign operands producing a different-sign result.
        w_alu_v   = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
      end
      OP_SUB: begin
        w_alu_res = w_diff[MSB:0];
        w_alu_c   = w_diff[WIDTH];
        // Opposite-sign operands where the result sign differs from A.
        w_alu_v   = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);
      end
      OP_OR:   w_alu_res = r_a | r_b;
      OP_AND:  w_alu_res = r_a & r_b;
      OP_XOR:  w_alu_res = r_a ^ r_b;
      default: w_alu_res = '0;
    endcase
  end

  always_comb begin
    w_alu_flags         = '0;
    w_alu_flags[FLAG_N] = w_alu_res[MSB];
    w_alu_flags[FLAG_Z] = (w_alu_res == '0);
    w_alu_flags[FLAG_C] = w_alu_c;
    w_alu_flags[FLAG_V] = w_alu_v;
  end

  // ---------------- sequencer ----------------
  // Undo is tested first in every state, which discards a coincident Enter.
  always_comb begin
    w_state_next  = r_state;
    w_a_next      = r_a;
    w_b_next      = r_b;
    w_op_next     = r_op;
    w_result_next = r_result;
    w_flags_next  = r_flags;
    case (r_state)
      WAIT_A: begin
        if (w_enter && !w_undo) begin
          w_a_next     = DataIn;
          w_state_next = WAIT_B;
        end
      end
      WAIT_B: begin
        if (w_undo) begin
          w_a_next     = '0;
          w_state_next = WAIT_A;
        end else if (w_enter) begin
          w_b_next     = DataIn;
          w_state_next = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (w_undo) begin
          w_b_next     = '0;
          w_state_next = WAIT_B;
        end else if (w_enter && is_legal_op(DataIn[2:0])) begin
          w_op_next     = op_t'(DataIn[2:0]);
          w_result_next = w_alu_res;
          w_flags_next  = w_alu_flags;
          w_state_next  = SHOW;
        end
      end
      SHOW: begin
        if (w_undo) begin
          w_result_next = '0;
          w_flags_next  = '0;
          w_state_next  = WAIT_OP;
        end else if (w_enter) begin
          w_a_next      = '0;
          w_b_next      = '0;
          w_op_next     = OP_ADD;
          w_result_next = '0;
          w_flags_next  = '0;
          w_state_next  = WAIT_A;
        end
      end
      default: begin
        w_a_next      = '0;
        w_b_next      = '0;
        w_op_next     = OP_ADD;
        w_result_next = '0;
        w_flags_next  = '0;
        w_state_next  = WAIT_A;
      end
    endcase
  end

  // Display follows the next state so the result appears together with SHOW.
  assign w_disp_next = (w_state_next == SHOW) ? w_result_next : DataIn;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= WAIT_A;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_result <= '0;
      r_flags  <= '0;
      r_disp   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_a      <= w_a_next;
      r_b      <= w_b_next;
      r_op     <= w_op_next;
      r_result <= w_result_next;
      r_flags  <= w_flags_next;
      r_disp   <= w_disp_next;
    end
  end

  assign ToDisplay = r_disp;
  assign Flags     = r_flags;
  assign Status    = r_state;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// ---------------------------------------------------------------------------
// tb_rpn_stack_calc
// Drives clean presses, glitches, coincident presses and resets, predicts
// when each accepted press must take effect, and compares Status, Flags and
// ToDisplay against a transaction-level model on every cycle. Directed
// sequences also pin hand-computed results.
// ---------------------------------------------------------------------------
module tb_rpn_stack_calc;

  localparam int W = 16;
  localparam int N = 10;
  // Raw rise -> 2 synchroniser edges + N samples + 1 update edge.
  localparam int LAT = N + 3;

  localparam int S_A = 0, S_B = 1, S_OP = 2, S_SHOW = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         Enter = 1'b0;
  logic         Undo = 1'b0;
  logic [W-1:0] DataIn = '0;
  logic [W-1:0] ToDisplay;
  logic [3:0]   Flags;
  logic [2:0]   Status;

  rpn_stack_calc #(.WIDTH(W), .N_DEBOUNCER(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .Enter     (Enter),
    .Undo      (Undo),
    .DataIn    (DataIn),
    .ToDisplay (ToDisplay),
    .Flags     (Flags),
    .Status    (Status)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int due;
    bit undo;
  } ev_t;
  ev_t evq[$];

  // Model state
  int           m_state;
  logic [W-1:0] m_a, m_b, m_res, m_disp;
  logic [3:0]   m_flags;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_compute(input logic [2:0] op);
    int ua, ub, sa, sb, full, smax, smin;
    bit c, v;
    ua = int'(m_a);
    ub = int'(m_b);
    sa = $signed(m_a);
    sb = $signed(m_b);
    smax = (1 << (W - 1)) - 1;
    smin = -(1 << (W - 1));
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        full = ua + ub;
        c = (full >= (1 << W));
        v = ((sa + sb) > smax) || ((sa + sb) < smin);
      end
      3'd1: begin
        full = ua - ub;
        c = (ua >= ub);
        v = ((sa - sb) > smax) || ((sa - sb) < smin);
      end
      3'd2: full = ua | ub;
      3'd3: full = ua & ub;
      default: full = ua ^ ub;
    endcase
    m_res   = full[W-1:0];
    m_flags = {m_res[W-1], (m_res == '0), c, v};
  endfunction

  function automatic void model_reset();
    m_state = S_A;
    m_a = '0; m_b = '0; m_res = '0; m_flags = '0;
  endfunction

  function automatic void model_step(input bit e, input bit u, input logic [W-1:0] d);
    if (u) begin
      case (m_state)
        S_B:    begin m_state = S_A;  m_a = '0; end
        S_OP:   begin m_state = S_B;  m_b = '0; end
        S_SHOW: begin m_state = S_OP; m_res = '0; m_flags = '0; end
        default: ;
      endcase
    end else if (e) begin
      case (m_state)
        S_A: begin m_a = d; m_state = S_B; end
        S_B: begin m_b = d; m_state = S_OP; end
        S_OP: begin
          if (d[2:0] <= 3'd4) begin
            model_compute(d[2:0]);
            m_state = S_SHOW;
          end
        end
        default: begin
          m_a = '0; m_b = '0; m_res = '0; m_flags = '0;
          m_state = S_A;
        end
      endcase
    end
  endfunction

  // Per-cycle compare, sampled 1 time unit after each rising edge.
  initial begin
    ev_t ev;
    bit  e, u;
    model_reset();
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        model_reset();
        evq.delete();
        m_disp = '0;
      end else begin
        e = 1'b0;
        u = 1'b0;
        while (evq.size() > 0 && evq[0].due <= cyc) begin
          ev = evq.pop_front();
          if (ev.undo) u = 1'b1; else e = 1'b1;
        end
        model_step(e, u, DataIn);
        m_disp = (m_state == S_SHOW) ? m_res : DataIn;
      end
      check("status", 32'(Status), 32'(m_state));
      check("flags", 32'(Flags), 32'(m_flags));
      check("display", 32'(ToDisplay), 32'(m_disp));
    end
  end

  // Press Enter and/or Undo for 'hold' cycles then release for 'gap' cycles.
  task automatic press(input bit e, input bit u, input logic [W-1:0] d,
                       input int hold, input int gap);
    @(negedge clk);
    DataIn = d;
    Enter  = e;
    Undo   = u;
    if (hold >= N) begin
      if (e) evq.push_back('{cyc + LAT, 1'b0});
      if (u) evq.push_back('{cyc + LAT, 1'b1});
    end
    repeat (hold) @(negedge clk);
    Enter = 1'b0;
    Undo  = 1'b0;
    repeat (gap) @(negedge clk);
    $display("txn: enter=%0b undo=%0b data=%h hold=%0d -> status=%0d disp=%h flags=%b",
             e, u, d, hold, Status, ToDisplay, Flags);
  endtask

  task automatic enter(input logic [W-1:0] d);
    press(1'b1, 1'b0, d, N + 5, N + 3);
  endtask

  task automatic undo();
    press(1'b0, 1'b1, DataIn, N + 5, N + 3);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] op);
    enter(a);
    enter(b);
    enter(op);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_status", 32'(Status), 32'd0);
    check("reset_flags", 32'(Flags), 32'd0);
    check("reset_disp", 32'(ToDisplay), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // ADD with carry
    run_op(16'hFFFF, 16'h0101, 16'h0000);
    check("add_status", 32'(Status), 32'd3);
    check("add_result", 32'(ToDisplay), 32'h0100);
    check("add_flags", 32'(Flags), 32'b0010);
    enter(16'h0000);
    check("add_clear_status", 32'(Status), 32'd0);
    check("add_clear_flags", 32'(Flags), 32'd0);

    // SUB and signed overflow
    run_op(16'hFFFF, 16'h0101, 16'h0001);
    check("sub_result", 32'(ToDisplay), 32'hFEFE);
    check("sub_flags", 32'(Flags), 32'b1010);
    enter(16'h0000);
    run_op(16'h7FFF, 16'h0001, 16'h0000);
    check("ovf_result", 32'(ToDisplay), 32'h8000);
    check("ovf_flags", 32'(Flags), 32'b1001);
    enter(16'h0000);

    // Logic ops
    run_op(16'hFFFF, 16'h0101, 16'h0002);
    check("or_result", 32'(ToDisplay), 32'hFFFF);
    check("or_flags", 32'(Flags), 32'b1000);
    enter(16'h0000);
    run_op(16'hFFFF, 16'h0003, 16'h0003);
    check("and_result", 32'(ToDisplay), 32'h0003);
    check("and_flags", 32'(Flags), 32'b0000);
    enter(16'h0000);
    run_op(16'h00FF, 16'h00FF, 16'h0004);
    check("xor_result", 32'(ToDisplay), 32'h0000);
    check("xor_flags", 32'(Flags), 32'b0100);
    enter(16'h0000);

    // Undo from SHOW keeps A and B
    run_op(16'hFFFF, 16'h0101, 16'h0000);
    undo();
    check("undo_show_status", 32'(Status), 32'd2);
    check("undo_show_flags", 32'(Flags), 32'd0);
    enter(16'h0001);
    check("undo_resub", 32'(ToDisplay), 32'hFEFE);
    enter(16'h0000);

    // Undo chain back to WAIT_A and beyond
    enter(16'h1234);
    enter(16'h5678);
    undo();
    check("undo_op_status", 32'(Status), 32'd1);
    undo();
    check("undo_b_status", 32'(Status), 32'd0);
    undo();
    check("undo_a_status", 32'(Status), 32'd0);

    // Glitch, long hold, coincident presses
    press(1'b1, 1'b0, 16'h0042, 6, N + 3);
    check("glitch_status", 32'(Status), 32'd0);
    press(1'b1, 1'b0, 16'h0042, 200, N + 3);
    check("hold_status", 32'(Status), 32'd1);
    press(1'b1, 1'b1, 16'h0099, N + 5, N + 3);
    check("coincident_status", 32'(Status), 32'd0);

    // Illegal opcode, then upper bits ignored on a legal one
    enter(16'h0010);
    enter(16'h0020);
    enter(16'h0006);
    check("illegal_op_status", 32'(Status), 32'd2);
    enter(16'hABC0);
    check("legal_op_status", 32'(Status), 32'd3);
    check("legal_op_result", 32'(ToDisplay), 32'h0030);
    enter(16'h0000);

    // Reset mid-operation, Enter held across release
    enter(16'h0011);
    enter(16'h0022);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_status", 32'(Status), 32'd0);
    check("midreset_disp", 32'(ToDisplay), 32'd0);
    check("midreset_flags", 32'(Flags), 32'd0);
    Enter  = 1'b1;
    DataIn = 16'h0777;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    evq.push_back('{cyc + LAT, 1'b0});
    repeat (LAT - 1) @(negedge clk);
    check("held_reset_early", 32'(Status), 32'd0);
    @(negedge clk);
    check("held_reset_pulse", 32'(Status), 32'd1);
    repeat (200) @(negedge clk);
    Enter = 1'b0;
    repeat (N + 3) @(negedge clk);
    check("held_reset_once", 32'(Status), 32'd1);

    // Randomized actions against the model
    for (int i = 0; i < 150; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 10) begin
        press(1'b1, 1'b0, W'($urandom), $urandom_range(N, N + 20), N + $urandom_range(0, 5));
      end else if (r < 14) begin
        press(1'b0, 1'b1, W'($urandom), $urandom_range(N, N + 20), N + $urandom_range(0, 5));
      end else if (r < 16) begin
        press(1'b1, 1'b1, W'($urandom), $urandom_range(N, N + 20), N + $urandom_range(0, 5));
      end else if (r < 19) begin
        press($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, W'($urandom),
              $urandom_range(1, N - 1), N + $urandom_range(0, 5));
      end else begin
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
      end
      repeat ($urandom_range(0, 5)) begin
        @(negedge clk);
        DataIn = W'($urandom);
      end
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
